// File: rtl/pipeline_bus_arbiter.sv
// pipeline_bus_arbiter
// Arbitrates the memory address/data bus between pipeline stage 2 and an
// external DMA requester. Grants are registered, ownership changes always
// pass through a single dead TURN cycle, handover is round-robin and DMA
// bursts are capped at DMA_MAX_BURST cycles when the pipeline is waiting.
// Optional build macro ARB_STATS_EN adds a saturating StallCount output.
module pipeline_bus_arbiter #(
  parameter int unsigned DMA_MAX_BURST = 8,
  parameter logic [2:0]  DMA_ADDR_SEL  = 3'b111
) (
  input  logic        ClockIn,
  input  logic        Reset,
  input  logic        PipeBusRequest,
  input  logic [2:0]  PipeAddrSel,
  input  logic        DmaReq,
  output logic        PipeGrant,
  output logic        DmaGrant,
  output logic        PipeStall,
  output logic [2:0]  AddrSel
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] StallCount
`endif
);

  typedef enum logic [1:0] {IDLE, PIPE, DMA, TURN} state_t;
  typedef enum logic {OWNER_PIPE, OWNER_DMA} owner_t;

  localparam logic [3:0] BURST_MAX  = 4'(DMA_MAX_BURST);
  localparam logic [3:0] BURST_LAST = 4'(DMA_MAX_BURST - 1);

  state_t     state;
  state_t     state_next;
  owner_t     last_owner;
  owner_t     last_owner_next;
  logic [3:0] burst_cnt;
  logic       burst_full;
  logic       pipe_grant_q;
  logic       dma_grant_q;

  // burst_cnt counts completed DMA cycles, so the current cycle is the
  // DMA_MAX_BURST-th granted one when the count reaches DMA_MAX_BURST-1.
  assign burst_full = (burst_cnt >= BURST_LAST);

  // State register, grant flops, ownership history and burst counter
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      last_owner   <= OWNER_PIPE;
      pipe_grant_q <= 1'b0;
      dma_grant_q  <= 1'b0;
      burst_cnt    <= '0;
    end else begin
      state        <= state_next;
      last_owner   <= last_owner_next;
      pipe_grant_q <= (state_next == PIPE);
      dma_grant_q  <= (state_next == DMA);
      if (state != DMA)
        burst_cnt <= '0;
      else if (burst_cnt != BURST_MAX)
        burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // Next-state and round-robin ownership decision
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    case (state)
      IDLE: begin
        if (PipeBusRequest)
          state_next = PIPE;
        else if (DmaReq)
          state_next = DMA;
      end
      PIPE: begin
        if (!PipeBusRequest) begin
          state_next      = TURN;
          last_owner_next = OWNER_PIPE;
        end
      end
      DMA: begin
        if (!DmaReq || (PipeBusRequest && burst_full)) begin
          state_next      = TURN;
          last_owner_next = OWNER_DMA;
        end
      end
      TURN: begin
        if (PipeBusRequest && DmaReq)
          state_next = (last_owner == OWNER_PIPE) ? DMA : PIPE;
        else if (PipeBusRequest)
          state_next = PIPE;
        else if (DmaReq)
          state_next = DMA;
        else
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: registered grants, stall and address-mux select
  always_comb begin
    PipeGrant = pipe_grant_q;
    DmaGrant  = dma_grant_q;
    PipeStall = PipeBusRequest & ~pipe_grant_q;
    if (pipe_grant_q)
      AddrSel = PipeAddrSel;
    else if (dma_grant_q)
      AddrSel = DMA_ADDR_SEL;
    else
      AddrSel = 3'b000;
  end

`ifdef ARB_STATS_EN
  // Saturating count of cycles in which the pipeline is stalled
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset)
      StallCount <= '0;
    else if (PipeStall && (StallCount != '1))
      StallCount <= StallCount + 16'd1;
  end
`endif

endmodule
